// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: bundles the command stream, response stream, status
// and APB bus signals of the APB master bridge.
//   master modport : bridge side (drives cmd_ready, rsp_*, busy, APB requests)
//   slave modport  : environment side (drives cmd_*, PRDATA/PREADY/PSLVERR)
interface apb_master_bridge_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
);
  // command stream
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [AWIDTH-1:0] cmd_addr;
  logic [DWIDTH-1:0] cmd_wdata;
  // response stream
  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              busy;
  // APB
  logic              PSELx;
  logic              PENABLE;
  logic [AWIDTH-1:0] PADDR;
  logic              PWRITE;
  logic [DWIDTH-1:0] PWDATA;
  logic [DWIDTH-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
           PSELx, PENABLE, PADDR, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
           PSELx, PENABLE, PADDR, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: converts a valid/ready command stream into APB
// SETUP/ACCESS transfers and returns one response pulse per command.
// A PREADY timeout (TIMEOUT ACCESS cycles, 0 = wait forever) terminates
// transfers to a hung slave with rsp_err=1, rsp_timeout=1.
// Ports:
//   PCLK     rising-edge clock
//   PRESETn  asynchronous active-low reset
//   bus      apb_master_bridge_if.master (cmd_*, rsp_*, busy, APB signals)
module apb_master_bridge #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  apb_master_bridge_if.master   bus
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          timeout_hit;
  logic          done;
  logic          accept;

  // PREADY in the expiry cycle takes priority over the timeout
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST) && !bus.PREADY;
  assign done        = (state == ACCESS) && (bus.PREADY || timeout_hit);

  // ready in IDLE, or in the completing ACCESS cycle for back-to-back issue
  assign bus.cmd_ready = (state == IDLE) || done;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.PSELx       <= 1'b0;
      bus.PENABLE     <= 1'b0;
      bus.PWRITE      <= 1'b0;
      bus.PADDR       <= '0;
      bus.PWDATA      <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            bus.PADDR   <= bus.cmd_addr;
            bus.PWRITE  <= bus.cmd_write;
            bus.PWDATA  <= bus.cmd_write ? bus.cmd_wdata : '0;
            bus.PSELx   <= 1'b1;
            bus.PENABLE <= 1'b0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          bus.PENABLE <= 1'b1;
          cnt         <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            bus.rsp_valid <= 1'b1;
            if (bus.PREADY) begin
              bus.rsp_err     <= bus.PSLVERR;
              bus.rsp_timeout <= 1'b0;
              // read data only returned for a clean read
              bus.rsp_rdata   <= (!bus.PWRITE && !bus.PSLVERR) ? bus.PRDATA : '0;
            end else begin
              bus.rsp_err     <= 1'b1;
              bus.rsp_timeout <= 1'b1;
              bus.rsp_rdata   <= '0;
            end
            bus.PENABLE <= 1'b0;
            if (accept) begin
              bus.PADDR  <= bus.cmd_addr;
              bus.PWRITE <= bus.cmd_write;
              bus.PWDATA <= bus.cmd_write ? bus.cmd_wdata : '0;
              state      <= SETUP;
            end else begin
              bus.PSELx <= 1'b0;
              state     <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
